fp_normalize_pipe: RTL and testbench

Two-stage pipelined normalizer between the FPU add/sub/mul mantissa datapaths and the rounding stage. Takes a raw, possibly overflowed or cancelled mantissa with biased exponent and produces the normalized fraction (hidden bit stripped, G/R/S appended), the adjusted exponent, and sign/mode, ready for direct connection to the rounder's `sign`/`in_frac`/`mode` inputs. Valid/ready handshake on both sides; full throughput of 1 op/cycle.

---
 rtl/fp_normalize_pipe.sv | 147 ++++++++++++++
 tb/tb_fp_normalize_pipe.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize_pipe.sv
`timescale 1ns/1ps
// fp_normalize_pipe: two-stage normalizer between the mantissa datapaths and
// the rounder. S1 registers the operation with its leading-zero count and path
// select; S2 shifts, adjusts the exponent and registers the rounder-facing outputs.
module fp_normalize_pipe #(
    parameter int exp_width  = 8,
    parameter int frac_width = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [exp_width-1:0]  in_exp,
    input  logic [frac_width+4:0] in_mant,
    input  logic                  in_sticky,
    input  logic [1:0]            in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign,
    output logic [1:0]            out_mode,
    output logic [frac_width+2:0] out_frac,
    output logic [exp_width-1:0]  out_exp,
    output logic                  out_zero,
    output logic                  out_ovf
);
    localparam int M   = frac_width + 5;
    localparam int LW  = $clog2(M);
    // Exponent math runs one bit wider than the larger of exponent / lzc widths
    // so e+1 and the min() compare never wrap.
    localparam int EW2 = ((exp_width > LW) ? exp_width : LW) + 1;
    localparam logic [EW2-1:0] ONE  = 1;
    localparam logic [EW2-1:0] EMAX = EW2'({exp_width{1'b1}});

    typedef enum logic [1:0] {PATH_LEFT, PATH_RIGHT, PATH_ZERO} path_t;

    typedef struct packed {
        logic                 sign;
        logic [1:0]           mode;
        logic [exp_width-1:0] exp;
        logic [M-2:0]         mant;   // carry bit is folded into the path select
        logic                 sticky;
        logic [LW-1:0]        lzc;
        path_t                path;
    } s1_t;

    logic [2:1]   vld_pipe;
    logic         s1_en, s2_en;
    logic [LW-1:0] lzc_c;
    s1_t          s1_d, s1_q;

    logic [EW2-1:0]        e_w, lzc_w, s_w, inc_w;
    logic [frac_width+2:0] nxt_frac;
    logic [exp_width-1:0]  nxt_exp;
    logic                  nxt_zero, nxt_ovf;

    // A stage may load when it is empty or the stage after it is moving.
    assign s2_en     = ~vld_pipe[2] | out_ready;
    assign s1_en     = ~vld_pipe[1] | s2_en;
    assign in_ready  = s1_en;
    assign out_valid = vld_pipe[2];

    // Leading zeros below the carry bit; ascending scan so the highest set bit wins.
    always_comb begin
        lzc_c = LW'(M - 1);
        for (int i = 0; i <= M - 2; i++)
            if (in_mant[i]) lzc_c = LW'(M - 2 - i);
    end

    // S1 capture: operation fields plus lzc and path select.
    always_comb begin
        s1_d.sign   = in_sign;
        s1_d.mode   = in_mode;
        s1_d.exp    = in_exp;
        s1_d.mant   = in_mant[M-2:0];
        s1_d.sticky = in_sticky;
        s1_d.lzc    = lzc_c;
        if (in_mant[M-1])      s1_d.path = PATH_RIGHT;
        else if (in_mant == '0) s1_d.path = PATH_ZERO;
        else                   s1_d.path = PATH_LEFT;
    end

    // S2 shift and exponent adjust; a biased exponent of 0 behaves as 1.
    always_comb begin
        e_w   = (s1_q.exp == '0) ? ONE : EW2'(s1_q.exp);
        lzc_w = EW2'(s1_q.lzc);
        inc_w = e_w + ONE;
        // Left shift stops at exponent 1 so subnormals keep their leading zeros.
        s_w   = (lzc_w < e_w - ONE) ? lzc_w : e_w - ONE;
        nxt_frac = '0;
        nxt_exp  = '0;
        nxt_zero = 1'b0;
        nxt_ovf  = 1'b0;
        case (s1_q.path)
            PATH_RIGHT: begin
                nxt_frac = {s1_q.mant[M-2:2], s1_q.mant[1] | s1_q.mant[0] | s1_q.sticky};
                if (inc_w >= EMAX) begin
                    nxt_exp = '1;
                    nxt_ovf = 1'b1;
                end else begin
                    nxt_exp = exp_width'(inc_w);
                end
            end
            PATH_ZERO: nxt_zero = 1'b1;
            default: begin
                nxt_frac    = (M-2)'(s1_q.mant << s_w);
                nxt_frac[0] = nxt_frac[0] | s1_q.sticky;
                nxt_exp     = (s_w == lzc_w) ? exp_width'(e_w - s_w) : '0;
            end
        endcase
    end

    // Valid shift register; reset flushes both stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            if (s1_en) vld_pipe[1] <= in_valid;
            if (s2_en) vld_pipe[2] <= vld_pipe[1];
        end
    end

    // S1 data register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      s1_q <= '0;
        else if (s1_en) s1_q <= s1_d;
    end

    // S2 output registers; held while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_sign <= 1'b0;
            out_mode <= '0;
            out_frac <= '0;
            out_exp  <= '0;
            out_zero <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (s2_en) begin
            out_sign <= s1_q.sign;
            out_mode <= s1_q.mode;
            out_frac <= nxt_frac;
            out_exp  <= nxt_exp;
            out_zero <= nxt_zero;
            out_ovf  <= nxt_ovf;
        end
    end
endmodule

// File: tb/tb_fp_normalize_pipe.sv
`timescale 1ns/1ps
// Bench for fp_normalize_pipe: directed table, latency/back-pressure/reset
// sequences, then randomized traffic scored against an arithmetic model.
module tb_fp_normalize_pipe;
    localparam int EW = 8, FW = 23, M = FW + 5;

    logic clk = 1'b0;
    logic reset, in_valid, in_ready, in_sign, in_sticky, out_valid, out_ready;
    logic out_sign, out_zero, out_ovf;
    logic [EW-1:0] in_exp, out_exp;
    logic [M-1:0]  in_mant;
    logic [1:0]    in_mode, out_mode;
    logic [FW+2:0] out_frac;

    always #5 clk = ~clk;

    fp_normalize_pipe #(.exp_width(EW), .frac_width(FW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
        .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_mode(out_mode), .out_frac(out_frac),
        .out_exp(out_exp), .out_zero(out_zero), .out_ovf(out_ovf)
    );

    typedef struct packed {
        logic        sign;
        logic [1:0]  mode;
        logic [25:0] frac;
        logic [7:0]  exp;
        logic        zero;
        logic        ovf;
    } res_t;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] mant;
        logic        sticky;
        logic [1:0]  mode;
        res_t        want;
    } vec_t;

    res_t got;
    assign got = {out_sign, out_mode, out_frac, out_exp, out_zero, out_ovf};

    int   vectors = 0, miscompares = 0, n_acc = 0;
    res_t exp_q[$];
    res_t held, front;
    bit   stall = 0;
    bit   rnd_done = 0;

    function automatic string fmt(res_t r);
        return $sformatf("sign=%0d mode=%0d frac=%h exp=%0d zero=%0d ovf=%0d",
                         r.sign, r.mode, r.frac, r.exp, r.zero, r.ovf);
    endfunction

    // Reference: normalize with integer arithmetic straight from the rules.
    function automatic res_t model(logic sg, logic [7:0] ex, logic [27:0] mt,
                                   logic st, logic [1:0] md);
        res_t   r;
        int     e, p, lz, s;
        longint m, t;
        r = '0;
        r.sign = sg;
        r.mode = md;
        m = longint'(mt);
        e = (ex == 0) ? 1 : int'(ex);
        if (m >= (64'd1 << 27)) begin
            m = m - (64'd1 << 27);
            r.frac = 26'(((m / 4) * 2) + (((m % 4) != 0 || st) ? 1 : 0));
            r.exp  = (e + 1 >= 255) ? 8'd255 : 8'(e + 1);
            r.ovf  = (e + 1 >= 255);
        end else if (m == 0) begin
            r.zero = 1'b1;
        end else begin
            p = 26;
            while ((m / (64'd1 << p)) == 0) p--;
            lz = 26 - p;
            s  = (lz < e - 1) ? lz : e - 1;
            t  = (m * (64'd1 << s)) % (64'd1 << 26);
            r.frac = 26'(t) | 26'(st);
            r.exp  = (s == lz) ? 8'(e - s) : 8'd0;
        end
        return r;
    endfunction

    function automatic vec_t mk(logic sg, logic [7:0] ex, logic [27:0] mt, logic st,
                                logic [1:0] md, logic [25:0] fr, logic [7:0] oe,
                                logic z, logic o);
        vec_t v;
        v.sign = sg; v.exp = ex; v.mant = mt; v.sticky = st; v.mode = md;
        v.want = {sg, md, fr, oe, z, o};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] g, input logic [63:0] w);
        vectors++;
        if (g !== w) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, g, w);
        end
    endtask

    // Present one op and hold it until accepted; queue its expected result.
    task automatic send(input logic sg, input logic [7:0] ex, input logic [27:0] mt,
                        input logic st, input logic [1:0] md, input res_t w);
        in_valid = 1'b1; in_sign = sg; in_exp = ex; in_mant = mt;
        in_sticky = st; in_mode = md;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(w);
                n_acc++;
                @(posedge clk);
                #1;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: in_ready stayed 0 for 200 cycles, expected 1");
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0) return;
            @(posedge clk); #1;
        end
        vectors++;
        miscompares++;
        $display("FAIL drain_timeout: %0d results still pending, expected 0", exp_q.size());
    endtask

    // Scoreboard: in-order result check plus stability while stalled.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            stall = 0;
        end else begin
            if (stall) begin
                vectors++;
                if (!out_valid || got !== held) begin
                    miscompares++;
                    $display("FAIL hold: got valid=%0d %s expected valid=1 %s",
                             out_valid, fmt(got), fmt(held));
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_out: got %s expected no output", fmt(got));
                end else begin
                    front = exp_q.pop_front();
                    if (got !== front) begin
                        miscompares++;
                        $display("FAIL result: got %s expected %s", fmt(got), fmt(front));
                    end
                end
            end
            stall = out_valid && !out_ready;
            held  = got;
        end
    end

    vec_t tbl[11];
    int   base;

    initial begin
        logic        sg, st;
        logic [7:0]  ex;
        logic [27:0] mt;
        logic [1:0]  md;

        tbl[0]  = mk(0, 127, 28'h4000005, 1, 0, 26'h0000005, 127, 0, 0);
        tbl[1]  = mk(0, 127, 28'h8000003, 0, 1, 26'h0000001, 128, 0, 0);
        tbl[2]  = mk(1, 254, 28'h8000000, 0, 2, 26'h0000000, 255, 0, 1);
        tbl[3]  = mk(0, 255, 28'h8000004, 0, 3, 26'h0000002, 255, 0, 1);
        tbl[4]  = mk(0, 127, 28'h0000100, 0, 0, 26'h0000000, 109, 0, 0);
        tbl[5]  = mk(1,   3, 28'h0000100, 0, 1, 26'h0000400,   0, 0, 0);
        tbl[6]  = mk(1,  77, 28'h0000000, 1, 2, 26'h0000000,   0, 1, 0);
        tbl[7]  = mk(0,  19, 28'h0000100, 0, 0, 26'h0000000,   1, 0, 0);
        tbl[8]  = mk(0,   0, 28'h0000100, 1, 3, 26'h0000101,   0, 0, 0);
        tbl[9]  = mk(1,   1, 28'hC000000, 1, 0, 26'h2000001,   2, 0, 0);
        tbl[10] = mk(0,  10, 28'h2000001, 1, 1, 26'h0000003,   9, 0, 0);

        reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
        in_sticky = 1'b0; in_mode = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_data", 64'(got), 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_out_valid_after", 64'(out_valid), 0);
        @(posedge clk); #1;

        // Directed table, streamed back to back.
        for (int i = 0; i < 11; i++)
            send(tbl[i].sign, tbl[i].exp, tbl[i].mant, tbl[i].sticky, tbl[i].mode, tbl[i].want);
        idle(1);
        drain();

        // Latency: visible after the second rising edge counting the accept edge.
        send(tbl[0].sign, tbl[0].exp, tbl[0].mant, tbl[0].sticky, tbl[0].mode, tbl[0].want);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_edge1", 64'(out_valid), 0);
        @(negedge clk);
        chk("lat_edge2", 64'(out_valid), 1);
        drain();
        idle(2);

        // Back-pressure: five ops against a stalled consumer.
        out_ready = 1'b0;
        base = n_acc;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    mt = 28'(32'h0001000 << i) | 28'(i);
                    send(i[0], 8'(100 + i), mt, i[1], 2'(i), model(i[0], 8'(100 + i), mt, i[1], 2'(i)));
                end
                idle(1);
            end
            begin
                for (int k = 0; k < 50 && n_acc < base + 2; k++) begin @(posedge clk); #2; end
                chk("bp_in_ready", 64'(in_ready), 0);
                repeat (3) begin
                    @(posedge clk); #2;
                    chk("bp_accepts", 64'(n_acc - base), 2);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_all_out", 64'(n_acc - base), 5);

        // Reset with ops in flight drops them.
        for (int i = 0; i < 3; i++)
            send(1'b0, 8'd50, 28'h4000000 | 28'(i), 1'b0, 2'd0,
                 model(1'b0, 8'd50, 28'h4000000 | 28'(i), 1'b0, 2'd0));
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1 chk("midrst_out_valid", 64'(out_valid), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 1);
        chk("midrst_out_valid_after", 64'(out_valid), 0);
        repeat (3) @(negedge clk);
        chk("midrst_no_ghost", 64'(out_valid), 0);
        @(posedge clk); #1;
        send(tbl[5].sign, tbl[5].exp, tbl[5].mant, tbl[5].sticky, tbl[5].mode, tbl[5].want);
        idle(1);
        drain();

        // Random traffic with random consumer stalls.
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    sg = 1'($urandom);
                    st = 1'($urandom);
                    md = 2'($urandom);
                    case ($urandom_range(0, 7))
                        0: ex = 8'd0;
                        1: ex = 8'd1;
                        2: ex = 8'($urandom_range(2, 30));
                        3: ex = 8'($urandom_range(253, 255));
                        default: ex = 8'($urandom);
                    endcase
                    case ($urandom_range(0, 5))
                        0: mt = 28'($urandom) | 28'h8000000;
                        1: mt = 28'd0;
                        default: mt = 28'($urandom & 32'h7FFFFFF) >> $urandom_range(0, 26);
                    endcase
                    send(sg, ex, mt, st, md, model(sg, ex, mt, st, md));
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                in_valid = 1'b0;
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("final_queue_empty", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
